// File: rtl/ucup_mem_arbiter.sv
// ucup_mem_arbiter: round-robin N:1 memory request arbiter with a grant lock
// that holds the selection while the memory stalls. An in-order routing FIFO
// records which port was granted so each response returns to its requester.
module ucup_mem_arbiter #(
  parameter int NumPorts       = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 4,
  localparam int BeWidth       = DataWidth / 8
) (
  input  logic                                  clk_sys_i,
  input  logic                                  rst_sys_i,
  input  logic [NumPorts-1:0]                   port_req_i,
  output logic [NumPorts-1:0]                   port_gnt_o,
  input  logic [NumPorts-1:0]                   port_we_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]      port_be_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]    port_addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]    port_wdata_i,
  output logic [NumPorts-1:0]                   port_rvalid_o,
  output logic [DataWidth-1:0]                  port_rdata_o,
  output logic                                  mem_req_o,
  output logic                                  mem_we_o,
  output logic [BeWidth-1:0]                    mem_be_o,
  output logic [AddrWidth-1:0]                  mem_addr_o,
  output logic [DataWidth-1:0]                  mem_wdata_o,
  input  logic                                  mem_gnt_i,
  input  logic                                  mem_rvalid_i,
  input  logic [DataWidth-1:0]                  mem_rdata_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  err_o
);

  localparam int PortIdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int PtrW     = $clog2(MaxOutstanding);
  localparam int CntW     = $clog2(MaxOutstanding + 1);

  logic [PortIdxW-1:0] r_rr_q;
  logic                r_lock_q;
  logic [PortIdxW-1:0] r_lock_port_q;
  logic [PortIdxW-1:0] r_fifo_q [MaxOutstanding];
  logic [PtrW-1:0]     r_wr_ptr_q;
  logic [PtrW-1:0]     r_rd_ptr_q;
  logic [CntW-1:0]     r_cnt_q;
  logic                r_err_q;

  logic                w_full;
  logic                w_empty;
  logic                w_lock_act;
  logic                w_rr_found;
  logic [PortIdxW-1:0] w_rr_sel;
  logic [PortIdxW-1:0] w_cand;
  logic [PortIdxW-1:0] w_sel;
  logic [PortIdxW-1:0] w_rr_next;
  logic [PortIdxW-1:0] w_head;
  logic                w_hs;
  logic                w_pop;
  logic                w_unexp;

  assign w_full  = (r_cnt_q == CntW'(MaxOutstanding));
  assign w_empty = (r_cnt_q == '0);
  assign w_head  = r_fifo_q[r_rd_ptr_q];

  // A lock only holds while its port keeps requesting; a dropped request
  // frees the arbiter to pick someone else in the same cycle.
  assign w_lock_act = r_lock_q && port_req_i[r_lock_port_q];

  // Round-robin search: first requester at or after r_rr_q, wrapping.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_sel   = r_rr_q;
    w_cand     = '0;
    for (int i = 0; i < NumPorts; i++) begin
      w_cand = PortIdxW'((int'(r_rr_q) + i) % NumPorts);
      if (!w_rr_found && port_req_i[w_cand]) begin
        w_rr_found = 1'b1;
        w_rr_sel   = w_cand;
      end
    end
  end

  assign w_sel     = w_lock_act ? r_lock_port_q : w_rr_sel;
  assign w_rr_next = (int'(w_sel) >= NumPorts - 1) ? '0 : w_sel + PortIdxW'(1);

  assign mem_req_o   = !rst_sys_i && ((|port_req_i) || w_lock_act) && !w_full;
  assign mem_we_o    = port_we_i[w_sel];
  assign mem_be_o    = port_be_i[w_sel];
  assign mem_addr_o  = port_addr_i[w_sel];
  assign mem_wdata_o = port_wdata_i[w_sel];

  assign w_hs    = mem_req_o && mem_gnt_i;
  assign w_pop   = !rst_sys_i && mem_rvalid_i && !w_empty;
  assign w_unexp = mem_rvalid_i && w_empty;

  assign port_rdata_o  = mem_rdata_i;
  assign outstanding_o = rst_sys_i ? '0 : r_cnt_q;
  assign err_o         = r_err_q && !rst_sys_i;

  // One-hot grant to the selected port on a downstream handshake.
  always_comb begin
    port_gnt_o = '0;
    if (w_hs) port_gnt_o[w_sel] = 1'b1;
  end

  // Route a response to the port recorded at the FIFO head.
  always_comb begin
    port_rvalid_o = '0;
    if (w_pop) port_rvalid_o[w_head] = 1'b1;
  end

  // Arbitration state, FIFO pointers/occupancy and the sticky error flag.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      r_rr_q        <= '0;
      r_lock_q      <= 1'b0;
      r_lock_port_q <= '0;
      r_wr_ptr_q    <= '0;
      r_rd_ptr_q    <= '0;
      r_cnt_q       <= '0;
      r_err_q       <= 1'b0;
    end else begin
      if (w_hs) r_rr_q <= w_rr_next;

      if (mem_req_o && !mem_gnt_i) begin
        r_lock_q      <= 1'b1;
        r_lock_port_q <= w_sel;
      end else if (!(w_lock_act && w_full)) begin
        r_lock_q <= 1'b0;
      end

      if (w_hs)  r_wr_ptr_q <= r_wr_ptr_q + PtrW'(1);
      if (w_pop) r_rd_ptr_q <= r_rd_ptr_q + PtrW'(1);
      if (w_hs && !w_pop)      r_cnt_q <= r_cnt_q + CntW'(1);
      else if (!w_hs && w_pop) r_cnt_q <= r_cnt_q - CntW'(1);

      if (w_unexp) r_err_q <= 1'b1;
    end
  end

  // Routing FIFO storage; contents are only meaningful below the occupancy.
  always_ff @(posedge clk_sys_i) begin
    if (w_hs) r_fifo_q[r_wr_ptr_q] <= w_sel;
  end

endmodule

// File: doc/ucup_mem_arbiter.md
UCUP_MEM_ARBITER -- requirements
Module: ucup_mem_arbiter

Interface
REQ-001 SHALL have parameter NumPorts, default 2, number of upstream requester ports (1..8).
REQ-002 SHALL have parameter AddrWidth, default 32, address width.
REQ-003 SHALL have parameter DataWidth, default 32, data width (multiple of 8); BeWidth = DataWidth/8.
REQ-004 SHALL have parameter MaxOutstanding, default 4, depth of the response-routing FIFO (power of 2, 2..16).
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk_sys_i  in  1  system clock, rising edge.
REQ-006 SHALL have rst_sys_i  in  1  synchronous active-high reset.
REQ-007 SHALL have port_req_i  in  NumPorts  per-port request.
REQ-008 SHALL have port_gnt_o  out  NumPorts  per-port grant.
REQ-009 SHALL have port_we_i  in  NumPorts  per-port write enable.
REQ-010 SHALL have port_be_i  in  NumPorts x BeWidth  per-port byte enables.
REQ-011 SHALL have port_addr_i  in  NumPorts x AddrWidth  per-port address.
REQ-012 SHALL have port_wdata_i  in  NumPorts x DataWidth  per-port write data.
REQ-013 SHALL have port_rvalid_o  out  NumPorts  per-port response valid.
REQ-014 SHALL have port_rdata_o  out  DataWidth  response data, broadcast to all ports.
REQ-015 SHALL have mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1/1/BeWidth/AddrWidth/DataWidth  downstream request.
REQ-016 SHALL have mem_gnt_i  in  1  downstream grant.
REQ-017 SHALL have mem_rvalid_i, mem_rdata_i  in  1/DataWidth  downstream in-order response; one per granted request, reads and writes.
REQ-018 SHALL have outstanding_o  out  $clog2(MaxOutstanding+1)  FIFO occupancy.
REQ-019 SHALL have err_o  out  1  sticky flag, set by an unexpected response.

Function
REQ-020 SHALL forward the selected port's we/be/addr/wdata to mem_* combinationally; mem_req_o = (any port_req_i, or lock) AND NOT full.
REQ-021 SHALL select the selected port by round-robin: search starts at pointer rr_q and takes the first requesting port in increasing index, modulo NumPorts.
REQ-022 SHALL update rr_q to (k+1) mod NumPorts on a handshake from port k (mem_req_o & mem_gnt_i), and otherwise hold rr_q.
REQ-023 SHALL assert port_gnt_o[k] = mem_req_o & mem_gnt_i & (selected == k); at most one grant bit is high per cycle.
REQ-024 SHALL lock on port k when mem_req_o is high and mem_gnt_i is low: it registers k, holds the selection on k the next cycle regardless of other requests, and releases the lock on the handshake.
REQ-025 SHALL release the lock if the locked port drops port_req_i (protocol violation) and re-arbitrate in that cycle without setting err_o.
REQ-026 SHALL push the granted port index into the FIFO on each handshake and pop the FIFO head on each mem_rvalid_i.
REQ-027 SHALL treat simultaneous push and pop as occupancy unchanged; full is occupancy == MaxOutstanding, and a pop in the same cycle does not unblock a push.
REQ-028 SHALL force mem_req_o = 0 and all port_gnt_o = 0 while full.
REQ-029 SHALL set port_rvalid_o[h] = mem_rvalid_i & not empty, where h is the FIFO head; port_rdata_o = mem_rdata_i, combinational with zero added latency.
REQ-030 SHALL, on mem_rvalid_i while empty, assert no port_rvalid_o, leave the FIFO unchanged, and set err_o the next cycle; err_o stays high until reset.
REQ-031 SHALL give back-to-back handshakes one per cycle when mem_gnt_i is held high and the FIFO is not full.
REQ-032 SHALL, with NumPorts = 1, degenerate to a pass-through with FIFO tracking; rr_q is constant 0.

Reset
REQ-033 SHALL, in a cycle where rst_sys_i is sampled high, set rr_q = 0, clear the lock, empty the FIFO (pointers 0), and clear err_o.
REQ-034 SHALL hold mem_req_o, port_gnt_o, port_rvalid_o, outstanding_o and err_o at 0 while rst_sys_i is high, regardless of inputs.
REQ-035 SHALL, on reset asserted mid-transaction, discard outstanding entries; responses arriving after reset set err_o.

Verification
REQ-036 SHALL cover: NumPorts=2, both ports requesting continuously, mem_gnt_i=1, 1-cycle rvalid -> grants alternate 0,1,0,1 and each rvalid goes to the matching port.
REQ-037 SHALL cover: port 1 requests with mem_gnt_i=0 for 3 cycles while port 0 rises in cycle 2 -> mem_addr_o stays at port 1's address, then port 1 is granted, then port 0.
REQ-038 SHALL cover: MaxOutstanding=4, mem_gnt_i=1, no rvalid -> 4 handshakes, outstanding_o=4, mem_req_o=0; one rvalid -> the next cycle allows 1 handshake.
REQ-039 SHALL cover: mem_rvalid_i pulse with the FIFO empty -> no port_rvalid_o and err_o=1 from the next cycle until reset.
REQ-040 SHALL cover: reset pulse with 3 requests outstanding -> outstanding_o=0, rr_q=0, all outputs 0 during reset.
REQ-041 SHALL cover: push and pop in the same cycle at occupancy 2 -> occupancy stays 2, correct port receives rvalid.
